// File: rtl/sevenseg_scan_pkg.sv
// Shared scan-state encoding, blank pattern and default board timing for sevenseg_scan.
// Constants only; no latency and no flow control.
package sevenseg_scan_pkg;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // At a 50 MHz board clock this gives 250 us per digit and 5 us of dead time.
    localparam int DEF_ON_CYCLES    = 12500;
    localparam int DEF_BLANK_CYCLES = 250;

endpackage

// File: rtl/sevenseg_digit_mux.sv
// Selects the 7-bit segment field and the enable bit of digit idx. Combinational, zero latency.
// No flow control; an out-of-range idx selects a dark digit.
module sevenseg_digit_mux
    import sevenseg_scan_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int IDX_W  = 3
) (
    input  logic [7*DIGITS-1:0] sevenseg,
    input  logic [DIGITS-1:0]   digit_en,
    input  logic [IDX_W-1:0]    idx,
    output logic [6:0]          seg,
    output logic                en
);

    always_comb begin
        seg = SEG_OFF;
        en  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                seg = sevenseg[7*i +: 7];
                en  = digit_en[i];
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode display scanner with dead time; outputs are registered with the state.
// Latency: patterns are sampled on entry to each digit's drive slot. No backpressure.
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int ON_CYCLES    = DEF_ON_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7*DIGITS-1:0] sevenseg,
    input  logic [DIGITS-1:0]   digit_en,
    output logic [6:0]          seg_n,
    output logic [DIGITS-1:0]   an_n,
    output logic                frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);

    scan_state_t       state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] an_nxt;
    logic              tick_nxt;
    logic [6:0]        sel_seg;
    logic              sel_en;

    sevenseg_digit_mux #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_digit_mux (
        .sevenseg (sevenseg),
        .digit_en (digit_en),
        .idx      (idx),
        .seg      (sel_seg),
        .en       (sel_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN_BLANK;
            idx        <= '0;
            cnt        <= '0;
            seg_n      <= SEG_OFF;
            an_n       <= '1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seg_n      <= seg_nxt;
            an_n       <= an_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_W'(1);
        seg_nxt   = seg_n;
        an_nxt    = an_n;
        tick_nxt  = 1'b0;
        unique case (state)
            SCAN_BLANK: begin
                seg_nxt = SEG_OFF;
                an_nxt  = '1;
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nxt = SCAN_DRIVE;
                    cnt_nxt   = '0;
                    // Pattern and enable are frozen here for the whole drive slot.
                    if (sel_en) begin
                        seg_nxt = sel_seg;
                        an_nxt  = ~(DIGITS'(1) << idx);
                    end
                end
            end
            SCAN_DRIVE: begin
                if (cnt == CNT_W'(ON_CYCLES - 1)) begin
                    state_nxt = SCAN_BLANK;
                    cnt_nxt   = '0;
                    seg_nxt   = SEG_OFF;
                    an_nxt    = '1;
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        idx_nxt  = '0;
                        tick_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = SCAN_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: an 8-digit instance (4 on, 2 blank) and a 3-digit
// instance (1 on, 1 blank), checked against a closed-form position-in-frame model.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [55:0] sevenseg = '1;
    logic [7:0]  digit_en = 8'hFF;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        frame_tick;

    logic        rst3 = 1'b1;
    logic [20:0] sevenseg3 = '1;
    logic [2:0]  digit_en3 = 3'b111;
    logic [6:0]  seg_n3;
    logic [2:0]  an_n3;
    logic        frame_tick3;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;
    bit armed3 = 1'b0;

    sevenseg_scan #(.DIGITS(8), .ON_CYCLES(4), .BLANK_CYCLES(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .sevenseg   (sevenseg),
        .digit_en   (digit_en),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    sevenseg_scan #(.DIGITS(3), .ON_CYCLES(1), .BLANK_CYCLES(1), .CNT_W(16)) dut3 (
        .clk        (clk),
        .rst        (rst3),
        .sevenseg   (sevenseg3),
        .digit_en   (digit_en3),
        .seg_n      (seg_n3),
        .an_n       (an_n3),
        .frame_tick (frame_tick3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_an(input int c, input int nd, input int on, input int bl,
                                          input logic [7:0] en);
        int p, d, o;
        logic [7:0] r;
        p = c % (nd * (on + bl));
        d = p / (on + bl);
        o = p % (on + bl);
        r = 8'hFF;
        if (o >= bl && en[d]) r[d] = 1'b0;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int c, input int nd, input int on, input int bl,
                                           input logic [7:0] en, input logic [55:0] pat);
        int p, d, o;
        p = c % (nd * (on + bl));
        d = p / (on + bl);
        o = p % (on + bl);
        if (o >= bl && en[d]) return pat[7*d +: 7];
        return 7'h7F;
    endfunction

    function automatic logic exp_ft(input int c, input int period);
        return (c > 0) && (c % period == 0);
    endfunction

    task automatic check_main(input string tag, input int c, input logic [7:0] en,
                              input logic [55:0] pat);
        check($sformatf("%s_an@%0d", tag, c), 32'(an_n), 32'(exp_an(c, 8, 4, 2, en)));
        check($sformatf("%s_seg@%0d", tag, c), 32'(seg_n), 32'(exp_seg(c, 8, 4, 2, en, pat)));
        check($sformatf("%s_ft@%0d", tag, c), 32'(frame_tick), 32'(exp_ft(c, 48)));
    endtask

    task automatic reset_main();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (armed)  check("onehot_an",  32'($countones(~an_n) <= 1), 32'd1);
        if (armed3) check("onehot_an3", 32'($countones(~an_n3) <= 1), 32'd1);
    end

    logic [55:0] pat;

    initial begin
        // Reset values while rst is held high
        rst = 1'b1;
        tick();
        tick();
        check("rst_an",  32'(an_n), 32'hFF);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_ft",  32'(frame_tick), 32'd0);
        armed = 1'b1;

        // All digits show 7'h40
        for (int i = 0; i < 8; i++) sevenseg[7*i +: 7] = 7'h40;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0 || c == 1 || c == 6 || c == 7) begin
                check($sformatf("t1_an@%0d", c), 32'(an_n), 32'hFF);
                check($sformatf("t1_seg@%0d", c), 32'(seg_n), 32'h7F);
            end else if (c >= 2 && c <= 5) begin
                check($sformatf("t1_an@%0d", c), 32'(an_n), 32'hFE);
                check($sformatf("t1_seg@%0d", c), 32'(seg_n), 32'h40);
            end else begin
                check($sformatf("t1_an@%0d", c), 32'(an_n), 32'hFD);
                check($sformatf("t1_seg@%0d", c), 32'(seg_n), 32'h40);
            end
            tick();
        end

        // Distinct patterns over two frames
        for (int i = 0; i < 8; i++) pat[7*i +: 7] = 7'(7'h10 + i);
        sevenseg = pat;
        reset_main();
        for (int c = 0; c <= 96; c++) begin
            check_main("t2", c, 8'hFF, pat);
            tick();
        end

        // Digit 2 disabled
        digit_en = 8'b1111_1011;
        reset_main();
        for (int c = 0; c <= 48; c++) begin
            check_main("t3", c, 8'b1111_1011, pat);
            tick();
        end
        digit_en = 8'hFF;

        // Mid-slot pattern change on digit 0
        for (int i = 0; i < 8; i++) sevenseg[7*i +: 7] = 7'h40;
        reset_main();
        tick(); tick(); tick();
        check("t4_seg@3", 32'(seg_n), 32'h40);
        sevenseg[6:0] = 7'h79;
        tick();
        check("t4_seg@4", 32'(seg_n), 32'h40);
        tick();
        check("t4_seg@5", 32'(seg_n), 32'h40);
        check("t4_an@5",  32'(an_n), 32'hFE);
        tick();
        check("t4_seg@6", 32'(seg_n), 32'h7F);
        check("t4_an@6",  32'(an_n), 32'hFF);
        for (int c = 6; c < 50; c++) tick();
        check("t4_seg@50", 32'(seg_n), 32'h79);
        check("t4_an@50",  32'(an_n), 32'hFE);

        // Reset during digit 5 drive slot
        sevenseg = pat;
        reset_main();
        for (int c = 0; c < 33; c++) tick();
        check("t5_an@33",  32'(an_n), 32'hDF);
        check("t5_seg@33", 32'(seg_n), 32'h15);
        rst = 1'b1;
        tick();
        check("t5_rst_an",  32'(an_n), 32'hFF);
        check("t5_rst_seg", 32'(seg_n), 32'h7F);
        check("t5_rst_ft",  32'(frame_tick), 32'd0);
        rst = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            check_main("t5", c, 8'hFF, pat);
            tick();
        end

        // Three digits, one cycle on, one cycle blank
        sevenseg3 = {7'h22, 7'h21, 7'h20};
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        armed3 = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            check($sformatf("t6_an@%0d", c), 32'({5'h1F, an_n3}), 32'(exp_an(c, 3, 1, 1, 8'hFF)));
            check($sformatf("t6_seg@%0d", c), 32'(seg_n3),
                  32'(exp_seg(c, 3, 1, 1, 8'hFF, {35'd0, sevenseg3})));
            check($sformatf("t6_ft@%0d", c), 32'(frame_tick3), 32'(exp_ft(c, 6)));
            tick();
        end

        armed  = 1'b0;
        armed3 = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
